// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared fetch-stage types, word constants and PC helper.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int                WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc_plus4;
        logic              misalign;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Brief    : Circular fetch-entry FIFO with clear, occupancy and registered head.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  fetch_entry_t       i_push_data,
    input  logic               i_pop,
    input  logic               i_clear,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_valid,
    output fetch_entry_t       o_head
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t              r_mem [DEPTH];
    logic [c_ptr_w-1:0]        r_head_ptr;
    logic [c_ptr_w-1:0]        r_tail_ptr;
    logic [CNT_W-1:0]          r_count;
    fetch_entry_t              r_head;

    logic                      w_do_push;
    logic                      w_do_pop;
    logic [c_ptr_w-1:0]        w_head_ptr_nxt;
    logic [CNT_W-1:0]          w_count_nxt;
    fetch_entry_t              w_head_nxt;

    assign w_do_push = i_push && !i_clear;
    assign w_do_pop  = i_pop && (r_count != '0) && !i_clear;

    // The head register is loaded with whatever will sit at the head after
    // this edge, bypassing the array when the pushed word lands there.
    always_comb begin
        w_head_ptr_nxt = r_head_ptr;
        if (w_do_pop)
            w_head_ptr_nxt = r_head_ptr + c_ptr_w'(1);

        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase

        w_head_nxt = r_mem[w_head_ptr_nxt];
        if (w_do_push && (r_tail_ptr == w_head_ptr_nxt))
            w_head_nxt = i_push_data;
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_tail_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
            r_head     <= '0;
        end else if (i_clear) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else begin
            if (w_do_push)
                r_tail_ptr <= r_tail_ptr + c_ptr_w'(1);
            r_head_ptr <= w_head_ptr_nxt;
            r_count    <= w_count_nxt;
            if (w_count_nxt != '0)
                r_head <= w_head_nxt;
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_head;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Single-outstanding instruction fetch with flush and decode FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [WORD_W-1:0] if_instr,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_pc_plus4,
    output logic              if_misalign,
    output logic              err_spurious
);

    localparam int               c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    fetch_state_e          r_state;
    logic                  r_req;
    logic [WORD_W-1:0]     r_addr;
    logic                  r_err;

    logic [c_cnt_w-1:0]    w_fifo_count;
    logic [c_cnt_w-1:0]    w_occupancy;
    logic                  w_accept;
    logic                  w_aligned;
    logic                  w_push;
    fetch_entry_t          w_push_data;
    logic                  w_pop;
    fetch_entry_t          w_head;

    // The outstanding request already owns a FIFO slot, so the FIFO never overflows.
    assign w_occupancy = w_fifo_count + c_cnt_w'(r_state == WAIT);
    assign pc_ready    = (r_state == IDLE) && !flush && (w_occupancy < c_depth);
    assign w_accept    = pc_valid && pc_ready;
    assign w_aligned   = (pc_in[1:0] == 2'b00);
    assign w_pop       = if_valid && if_ready;

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        if (!flush) begin
            if ((r_state == WAIT) && imem_rvalid) begin
                w_push      = 1'b1;
                w_push_data = '{instr: imem_rdata, pc: r_addr,
                                pc_plus4: next_pc(r_addr), misalign: 1'b0};
            end else if (w_accept && !w_aligned) begin
                w_push      = 1'b1;
                w_push_data = '{instr: NOP_WORD, pc: pc_in,
                                pc_plus4: next_pc(pc_in), misalign: 1'b1};
            end
        end
    end

    // r_addr doubles as the latched PC of the outstanding fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_req <= w_accept && w_aligned;
            if (w_accept && w_aligned)
                r_addr <= pc_in;
            case (r_state)
                IDLE: begin
                    if (imem_rvalid)
                        r_err <= 1'b1;
                    if (w_accept && w_aligned)
                        r_state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid)
                        r_state <= IDLE;
                    else if (flush)
                        r_state <= DROP;
                end
                DROP: begin
                    if (imem_rvalid)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (c_cnt_w)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_clear     (flush),
        .o_count     (w_fifo_count),
        .o_valid     (if_valid),
        .o_head      (w_head)
    );

    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign err_spurious = r_err;
    assign if_instr     = w_head.instr;
    assign if_pc        = w_head.pc;
    assign if_pc_plus4  = w_head.pc_plus4;
    assign if_misalign  = w_head.misalign;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Brief    : Directed plus randomized bench for ifetch_unit against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;
    import mips_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP_W = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_misalign;
    logic        err_spurious;

    int n_cmp = 0;
    int n_bad = 0;

    ifetch_unit #(.DEPTH(DEPTH), .NOP_WORD(NOP_W)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .if_misalign(if_misalign), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected decode queue plus "request pending" / "response to discard".
    fetch_entry_t exp_q[$];
    bit           m_busy = 1'b0;
    bit           m_drop = 1'b0;
    logic [31:0]  m_pc   = '0;
    bit           m_req  = 1'b0;
    logic [31:0]  m_addr = '0;
    bit           m_err  = 1'b0;

    function automatic bit exp_ready();
        return !m_busy && !flush && (exp_q.size() < DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_busy = 0; m_drop = 0; m_pc = '0; m_req = 0; m_addr = '0; m_err = 0;
        end else begin
            bit acc;
            acc   = pc_valid && exp_ready();
            m_req = acc && (pc_in[1:0] == 2'b00);
            if (m_req) m_addr = pc_in;
            if (flush) begin
                exp_q.delete();
                if (m_busy) begin
                    if (imem_rvalid) begin m_busy = 0; m_drop = 0; end
                    else m_drop = 1;
                end else if (imem_rvalid) m_err = 1;
            end else begin
                if (exp_q.size() > 0 && if_ready) void'(exp_q.pop_front());
                if (m_busy && imem_rvalid) begin
                    if (!m_drop)
                        exp_q.push_back('{instr: imem_rdata, pc: m_pc,
                                          pc_plus4: m_pc + 32'd4, misalign: 1'b0});
                    m_busy = 0; m_drop = 0;
                end else if (!m_busy && imem_rvalid) m_err = 1;
                if (acc) begin
                    if (pc_in[1:0] == 2'b00) begin m_busy = 1; m_pc = pc_in; end
                    else exp_q.push_back('{instr: NOP_W, pc: pc_in,
                                           pc_plus4: pc_in + 32'd4, misalign: 1'b1});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("if_valid", {31'd0, if_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                chk("if_instr", if_instr, exp_q[0].instr);
                chk("if_pc", if_pc, exp_q[0].pc);
                chk("if_pc_plus4", if_pc_plus4, exp_q[0].pc_plus4);
                chk("if_misalign", {31'd0, if_misalign}, {31'd0, exp_q[0].misalign});
            end
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
            if (m_req) chk("imem_addr", imem_addr, m_addr);
            chk("pc_ready", {31'd0, pc_ready}, {31'd0, exp_ready()});
            chk("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] d);
        imem_rvalid = 1'b1; imem_rdata = d;
        step();
        imem_rvalid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        pc_in = pc; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int mem_cnt;
        logic [31:0] r;
        mem_cnt = 0;
        step(); step();
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
        chk("rst_err", {31'd0, err_spurious}, 32'd0);
        rst = 1'b0;
        step();

        // Basic fetch
        fetch(32'h0040_0000);
        chk("basic_req", {31'd0, imem_req}, 32'd1);
        chk("basic_addr", imem_addr, 32'h0040_0000);
        step();
        chk("basic_req_pulse", {31'd0, imem_req}, 32'd0);
        respond(32'h2008_0005);
        chk("basic_valid", {31'd0, if_valid}, 32'd1);
        chk("basic_instr", if_instr, 32'h2008_0005);
        chk("basic_pc", if_pc, 32'h0040_0000);
        chk("basic_pc4", if_pc_plus4, 32'h0040_0004);
        if_ready = 1'b1; step(); if_ready = 1'b0;

        // Backpressure with DEPTH=2
        fetch(32'h0000_0000);
        step();
        respond(32'h1111_0000);
        fetch(32'h0000_0004);
        chk("bp_ready_low", {31'd0, pc_ready}, 32'd0);
        step();
        respond(32'h1111_0004);
        chk("bp_still_low", {31'd0, pc_ready}, 32'd0);
        if_ready = 1'b1;
        chk("bp_first_pc", if_pc, 32'h0000_0000);
        step();
        chk("bp_second_pc", if_pc, 32'h0000_0004);
        chk("bp_ready_back", {31'd0, pc_ready}, 32'd1);
        step();
        if_ready = 1'b0;

        // Flush while a request is outstanding
        fetch(32'h0000_0100);
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_drop_ready", {31'd0, pc_ready}, 32'd0);
        respond(32'hDEAD_BEEF);
        chk("flush_no_entry", {31'd0, if_valid}, 32'd0);
        chk("flush_ready_back", {31'd0, pc_ready}, 32'd1);
        fetch(32'h0000_0200);
        step();
        respond(32'h3333_3333);
        chk("flush_next_instr", if_instr, 32'h3333_3333);
        chk("flush_next_pc", if_pc, 32'h0000_0200);
        if_ready = 1'b1; step(); if_ready = 1'b0;

        // Misaligned PC
        fetch(32'h0000_0006);
        chk("mis_no_req", {31'd0, imem_req}, 32'd0);
        chk("mis_valid", {31'd0, if_valid}, 32'd1);
        chk("mis_flag", {31'd0, if_misalign}, 32'd1);
        chk("mis_instr", if_instr, NOP_W);
        chk("mis_pc4", if_pc_plus4, 32'h0000_000A);
        if_ready = 1'b1; step(); if_ready = 1'b0;

        // PC wrap, then an unsolicited response
        fetch(32'hFFFF_FFFC);
        step();
        respond(32'h1234_5678);
        chk("wrap_pc4", if_pc_plus4, 32'h0000_0000);
        respond(32'h5555_5555);
        chk("spur_set", {31'd0, err_spurious}, 32'd1);
        step(); step();
        chk("spur_sticky", {31'd0, err_spurious}, 32'd1);

        // Asynchronous reset while waiting for memory
        fetch(32'h0000_0300);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_instr", if_instr, 32'd0);
        chk("arst_pc", if_pc, 32'd0);
        chk("arst_pc4", if_pc_plus4, 32'd0);
        chk("arst_mis", {31'd0, if_misalign}, 32'd0);
        chk("arst_err", {31'd0, err_spurious}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Randomized traffic with a memory that answers 1..3 cycles after each request
        for (int c = 0; c < 4000; c++) begin
            pc_valid = ($urandom_range(0, 2) != 0);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            pc_in    = r;
            flush    = ($urandom_range(0, 15) == 0);
            if_ready = ($urandom_range(0, 2) != 0);
            imem_rvalid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = $urandom;
                end
            end else if (!imem_req && $urandom_range(0, 299) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
            end
            if (imem_req) mem_cnt = $urandom_range(1, 3);
            step();
        end
        pc_valid = 1'b0; flush = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
